uart_reg_bridge: RTL and testbench
==================================

UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1_000_000, inter-byte timeout in clk cycles (max 2^20-1).
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rx_rdy  input  1  UART received-byte-valid level.
REQ-005 rx_data  input  8  UART received byte.
REQ-006 clr_rx_rdy  output  1  consume pulse to UART; combinational, high only in the acceptance cycle.
REQ-007 trmt  output  1  one-cycle start-transmit pulse to UART.
REQ-008 tx_data  output  8  byte to transmit; registered.
REQ-009 tx_done  input  1  UART transmit-complete level; low after trmt, high at frame end.
REQ-010 reg_addr  output  4  register address; registered.
REQ-011 reg_wdata  output  8  register write data; registered.
REQ-012 reg_we  output  1  one-cycle register write strobe.
REQ-013 reg_rdata  input  8  combinational read data for reg_addr.

Function
REQ-014 Command byte: bit7 = 1 write / 0 read; bits6:4 must be 000; bits3:0 = address.
REQ-015 States: IDLE, GET_DATA, READ, SEND, WAIT_TX; no others.
REQ-016 IDLE: rx_rdy=1 -> accept byte (clr_rx_rdy=1 same cycle), load reg_addr=rx_data[3:0].
REQ-017 Accepted byte with bits6:4 != 000 -> SEND with tx_data=0x15 (NAK); reg_we never asserted.
REQ-018 Valid write command -> GET_DATA, timeout counter cleared.
REQ-019 GET_DATA: rx_rdy=1 in cycle T -> clr_rx_rdy=1 in T; in T+1 reg_we=1, reg_wdata=byte, trmt=1, tx_data=0x06 (ACK); state WAIT_TX.
REQ-020 GET_DATA: counter reaches TIMEOUT_CYC-1 with no byte -> IDLE, no response, no write.
REQ-021 Valid read command accepted in T -> READ in T+1 (reg_addr valid); tx_data captures reg_rdata at end of T+1; trmt=1 in T+2.
REQ-022 NAK: trmt=1 in cycle after acceptance.
REQ-023 trmt high exactly one cycle per response; tx_data stable from trmt until tx_done observed.
REQ-024 WAIT_TX: tx_done sampled starting the cycle after trmt; tx_done=1 -> IDLE.
REQ-025 rx_rdy in SEND/WAIT_TX/READ: not consumed (clr_rx_rdy=0); byte handled once back in IDLE.
REQ-026 IDLE with rx_rdy=1 continuously: back-to-back commands, one accepted per visit to IDLE.
REQ-027 reg_addr holds last value outside commands; reg_we low except REQ-019 cycle.
REQ-028 Exactly one response byte per accepted command, except timeout (none).

Reset
REQ-029 rst_n low -> state IDLE, trmt=0, reg_we=0, tx_data=0x00, reg_addr=0, reg_wdata=0x00, counter 0, immediately.
REQ-030 Reset mid-command or mid-transmission aborts; no pending response or write after release.
REQ-031 clr_rx_rdy=0 while rst_n low.

Structure
REQ-032 Package uart_bridge_pkg holds state enum, ACK=0x06, NAK=0x15, command field positions.
REQ-033 Single module, no sub-modules; timeout counter inline, 20 bits.

Verification
REQ-034 Write: bytes 0x83, 0x5A -> reg_we one pulse, reg_addr=3, reg_wdata=0x5A, trmt with tx_data=0x06.
REQ-035 Read: reg model addr 7=0xC3; byte 0x07 -> trmt two cycles after acceptance, tx_data=0xC3, reg_we never high.
REQ-036 Invalid: byte 0x95 -> tx_data=0x15, no reg_we, back to IDLE after tx_done.
REQ-037 Timeout: TIMEOUT_CYC=16, byte 0x81 then silence 20 cycles -> no trmt, no reg_we; next 0x02 answered normally.
REQ-038 Byte arriving while tx_done low -> clr_rx_rdy stays 0 until tx_done=1, then consumed and answered.
REQ-039 rst_n pulsed during WAIT_TX -> all outputs reset values, no further trmt until new command.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge_pkg
// Description : Shared types and constants for the UART register bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_DATA = 3'd1,
        ST_READ     = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAIT_TX  = 3'd4
    } state_t;

    localparam logic [7:0] c_ack = 8'h06;
    localparam logic [7:0] c_nak = 8'h15;

    // Command byte layout: {write, reserved[2:0], address[3:0]}
    localparam int c_cmd_wr_bit   = 7;
    localparam int c_cmd_rsv_msb  = 6;
    localparam int c_cmd_rsv_lsb  = 4;
    localparam int c_cmd_addr_msb = 3;
    localparam int c_cmd_addr_lsb = 0;

    localparam int c_cnt_w = 20;

endpackage
`default_nettype wire

// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_bridge
// Description : Byte-command UART to register-bus bridge with ACK/NAK replies.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_bridge #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       clr_rx_rdy,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata
);

    import uart_bridge_pkg::*;

    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYC - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_trmt;
    logic                 r_reg_we;
    logic [7:0]           r_tx_data;
    logic [3:0]           r_reg_addr;
    logic [7:0]           r_reg_wdata;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_rsv_bad;
    logic                 w_is_write;
    logic                 w_accept_cmd;
    logic                 w_accept_data;
    logic                 w_trmt_set;

    assign w_rsv_bad  = |rx_data[c_cmd_rsv_msb:c_cmd_rsv_lsb];
    assign w_is_write = rx_data[c_cmd_wr_bit];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rx_rdy) begin
                    if (w_rsv_bad)       w_next = ST_SEND;
                    else if (w_is_write) w_next = ST_GET_DATA;
                    else                 w_next = ST_READ;
                end
            end
            ST_GET_DATA: begin
                if (rx_rdy)                         w_next = ST_WAIT_TX;
                else if (r_cnt == c_timeout_last)   w_next = ST_IDLE;
            end
            ST_READ:    w_next = ST_SEND;
            ST_SEND:    w_next = ST_WAIT_TX;
            // The ACK path enters here with trmt still high; tx_done only counts after it.
            ST_WAIT_TX: if (tx_done && !r_trmt) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept_cmd  = (r_state == ST_IDLE) && rx_rdy;
        w_accept_data = (r_state == ST_GET_DATA) && rx_rdy;
        w_trmt_set    = (w_accept_cmd && w_rsv_bad) || w_accept_data || (r_state == ST_READ);
        clr_rx_rdy    = rst_n && (w_accept_cmd || w_accept_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trmt      <= 1'b0;
            r_reg_we    <= 1'b0;
            r_tx_data   <= 8'h00;
            r_reg_addr  <= 4'h0;
            r_reg_wdata <= 8'h00;
            r_cnt       <= '0;
        end else begin
            r_trmt   <= w_trmt_set;
            r_reg_we <= w_accept_data;
            if (w_accept_cmd) begin
                r_reg_addr <= rx_data[c_cmd_addr_msb:c_cmd_addr_lsb];
                if (w_rsv_bad) r_tx_data <= c_nak;
            end
            if (w_accept_data) begin
                r_reg_wdata <= rx_data;
                r_tx_data   <= c_ack;
            end
            if (r_state == ST_READ) r_tx_data <= reg_rdata;
            if (r_state == ST_GET_DATA) r_cnt <= r_cnt + {{(c_cnt_w-1){1'b0}}, 1'b1};
            else                        r_cnt <= '0;
        end
    end

    assign trmt      = r_trmt;
    assign reg_we    = r_reg_we;
    assign tx_data   = r_tx_data;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_reg_bridge
// Description : Scoreboard bench for uart_reg_bridge with UART and register models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;

    localparam int c_tx_len = 8;

    logic       clk;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;

    logic [7:0] regs [16];
    assign reg_rdata = regs[reg_addr];

    uart_reg_bridge #(.TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_rdata  (reg_rdata)
    );

    typedef struct { logic [7:0] b; int lat; } tx_exp_t;
    typedef struct { logic [3:0] a; logic [7:0] d; } wr_exp_t;
    tx_exp_t txq [$];
    wr_exp_t wrq [$];

    int n_cmp;
    int n_fail;
    int cyc;
    int last_acc;
    logic busy;
    logic tx_abort;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and UART transmitter model: pops expectations when the DUT responds.
    initial begin
        tx_exp_t te;
        wr_exp_t we;
        logic [7:0] hold_tx;
        int txcnt;
        logic prev_trmt;
        tx_done   = 1'b1;
        busy      = 1'b0;
        tx_abort  = 1'b0;
        txcnt     = 0;
        prev_trmt = 1'b0;
        last_acc  = 0;
        hold_tx   = 8'h00;
        forever begin
            @(negedge clk);
            if (clr_rx_rdy) begin
                check("clr_while_tx_busy", {31'd0, busy}, 32'd0);
                last_acc = cyc;
            end
            if (trmt) begin
                check("trmt_single_pulse", {31'd0, prev_trmt}, 32'd0);
                if (txq.size() == 0) begin
                    check("unexpected_trmt", 32'd1, 32'd0);
                end else begin
                    te = txq.pop_front();
                    check("tx_data", {24'd0, tx_data}, {24'd0, te.b});
                    check("trmt_latency", cyc - last_acc, te.lat);
                end
                hold_tx = tx_data;
                busy    = 1'b1;
                txcnt   = c_tx_len;
                tx_done = 1'b0;
            end else if (busy) begin
                if (rst_n && !tx_abort) check("tx_data_stable", {24'd0, tx_data}, {24'd0, hold_tx});
                txcnt--;
                if (txcnt == 0) begin
                    busy     = 1'b0;
                    tx_done  = 1'b1;
                    tx_abort = 1'b0;
                end
            end
            prev_trmt = trmt;
            if (reg_we) begin
                if (wrq.size() == 0) begin
                    check("unexpected_reg_we", 32'd1, 32'd0);
                end else begin
                    we = wrq.pop_front();
                    check("reg_addr", {28'd0, reg_addr}, {28'd0, we.a});
                    check("reg_wdata", {24'd0, reg_wdata}, {24'd0, we.d});
                end
                regs[reg_addr] = reg_wdata;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        rx_rdy  = 1'b1;
        rx_data = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("byte_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b, input int lat);
        tx_exp_t e;
        e.b = b;
        e.lat = lat;
        txq.push_back(e);
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
        wr_exp_t e;
        e.a = a;
        e.d = d;
        wrq.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clr_rx_rdy"}, {31'd0, clr_rx_rdy}, 32'd0);
        check({tag, "_trmt"},       {31'd0, trmt},       32'd0);
        check({tag, "_reg_we"},     {31'd0, reg_we},     32'd0);
        check({tag, "_tx_data"},    {24'd0, tx_data},    32'd0);
        check({tag, "_reg_addr"},   {28'd0, reg_addr},   32'd0);
        check({tag, "_reg_wdata"},  {24'd0, reg_wdata},  32'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        regs[7] = 8'hC3;
        regs[2] = 8'h4E;
        rst_n   = 1'b0;
        rx_rdy  = 1'b1;
        rx_data = 8'h83;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rx_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x5A to address 3
        push_tx(8'h06, 1);
        push_wr(4'h3, 8'h5A);
        send_byte(8'h83);
        send_byte(8'h5A);

        // Read address 7 while the ACK is still being transmitted
        push_tx(8'hC3, 2);
        send_byte(8'h07);

        // Read back the written register
        push_tx(8'h5A, 2);
        send_byte(8'h03);

        // Reserved bits set: NAK
        push_tx(8'h15, 1);
        send_byte(8'h95);
        push_tx(8'h15, 1);
        send_byte(8'hF0);

        // Write command abandoned by timeout; next byte is a fresh command
        send_byte(8'h81);
        repeat (20) @(negedge clk);
        push_tx(8'h4E, 2);
        send_byte(8'h02);

        // Reset while transmitting the reply
        push_tx(8'hC3, 2);
        send_byte(8'h07);
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n    = 1'b0;
        tx_abort = 1'b1;
        #1;
        rx_rdy   = 1'b1;
        rx_data  = 8'h85;
        #1;
        check_reset_outputs("midtx_reset");
        repeat (2) @(negedge clk);
        rx_rdy = 1'b0;
        rst_n  = 1'b1;
        repeat (30) @(negedge clk);

        // Fresh write and read-back after reset
        push_tx(8'h06, 1);
        push_wr(4'h9, 8'hA5);
        send_byte(8'h89);
        send_byte(8'hA5);
        push_tx(8'hA5, 2);
        send_byte(8'h09);

        for (int i = 0; i < 100 && (txq.size() != 0 || wrq.size() != 0 || busy); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("tx_queue_drained", txq.size(), 32'd0);
        check("wr_queue_drained", wrq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
